// File: rtl/lsu_req_ctrl.sv
// lsu_req_ctrl: load/store request controller; aligns and lane-shifts an access,
// runs the memory req/rsp handshake with timeout, and returns extended load data.
module lsu_req_ctrl #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_is_store,
  input  logic [1:0]        ex_size,
  input  logic              ex_unsigned,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic              ex_ready,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wmask,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_rdata,
  output logic              wb_misalign,
  output logic              wb_buserr
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_e;
  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [2:0]  off_q;
  logic        mis;
  logic [7:0]  base_mask;
  logic [DATA_W-1:0] sh, ld;
  always_comb begin
    mis = (ex_size == 2'd1 && ex_addr[0]) || (ex_size == 2'd2 && |ex_addr[1:0]) ||
          (ex_size == 2'd3 && |ex_addr[2:0]);
    base_mask = ex_size == 2'd0 ? 8'h01 : ex_size == 2'd1 ? 8'h03 : ex_size == 2'd2 ? 8'h0f : 8'hff;
    sh = mem_rdata >> {off_q, 3'b000};
    ld = size_q == 2'd0 ? {{(DATA_W-8){~uns_q & sh[7]}}, sh[7:0]} :
         size_q == 2'd1 ? {{(DATA_W-16){~uns_q & sh[15]}}, sh[15:0]} :
         size_q == 2'd2 ? {{(DATA_W-32){~uns_q & sh[31]}}, sh[31:0]} : sh;
  end
  assign ex_ready = state_q == IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      size_q        <= '0;
      uns_q         <= 1'b0;
      off_q         <= '0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wmask     <= '0;
      mem_wdata     <= '0;
      wb_valid      <= 1'b0;
      wb_rdata      <= '0;
      wb_misalign   <= 1'b0;
      wb_buserr     <= 1'b0;
    end else begin
      wb_valid    <= 1'b0;
      wb_misalign <= 1'b0;
      wb_buserr   <= 1'b0;
      case (state_q)
        IDLE: if (ex_valid) begin
          mem_addr  <= {ex_addr[ADDR_W-1:3], 3'b000};
          mem_we    <= ex_is_store;
          mem_wmask <= ex_is_store ? base_mask << ex_addr[2:0] : 8'h00;
          mem_wdata <= ex_is_store ? ex_wdata << {ex_addr[2:0], 3'b000} : '0;
          size_q    <= ex_size;
          uns_q     <= ex_unsigned;
          off_q     <= ex_addr[2:0];
          if (mis) begin
            state_q     <= DONE;
            wb_valid    <= 1'b1;
            wb_misalign <= 1'b1;
            wb_rdata    <= '0;
          end else begin
            state_q       <= REQ;
            mem_req_valid <= 1'b1;
          end
        end
        REQ: if (mem_req_ready) begin
          state_q       <= WAIT_RSP;
          mem_req_valid <= 1'b0;
          cnt_q         <= '0;
        end
        // a response in the final counted cycle still completes normally
        WAIT_RSP: if (mem_rsp_valid) begin
          state_q  <= DONE;
          wb_valid <= 1'b1;
          wb_rdata <= mem_we ? '0 : ld;
        end else begin
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == 8'(TIMEOUT - 1)) begin
            state_q   <= DONE;
            wb_valid  <= 1'b1;
            wb_buserr <= 1'b1;
            wb_rdata  <= '0;
          end
        end
        DONE: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_req_ctrl.sv
// tb_lsu_req_ctrl: randomized and directed accesses checked against a behavioural
// model of alignment, lane masks, load extension, handshake and timeout.
module tb_lsu_req_ctrl;
  localparam int TO = 4;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        ex_valid = 1'b0, ex_is_store = 1'b0, ex_unsigned = 1'b0;
  logic [1:0]  ex_size = '0;
  logic [63:0] ex_addr = '0, ex_wdata = '0;
  logic        ex_ready, mem_req_valid, mem_we, mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
  logic [63:0] mem_addr, mem_wdata, mem_rdata = '0, wb_rdata;
  logic [7:0]  mem_wmask;
  logic        wb_valid, wb_misalign, wb_buserr;
  int checks = 0, errors = 0;

  lsu_req_ctrl #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_store(ex_is_store),
    .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_ready(ex_ready), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
    .wb_rdata(wb_rdata), .wb_misalign(wb_misalign), .wb_buserr(wb_buserr));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ld_model(input logic [63:0] rd, input int off, input int sz, input bit un);
    int bits = 8 << sz;
    logic [63:0] v = rd >> (8 * off);
    logic [63:0] lim;
    if (bits == 64) return v;
    lim = 64'd1 << bits;
    v = v % lim;
    if (!un && v >= (lim >> 1)) v = v - lim;
    return v;
  endfunction

  task automatic scramble_ex();
    ex_is_store = 1'($urandom);
    ex_size     = 2'($urandom);
    ex_unsigned = 1'($urandom);
    ex_addr     = {$urandom, $urandom};
    ex_wdata    = {$urandom, $urandom};
  endtask

  // One access driven and checked from a negedge with the DUT idle; returns at a negedge, idle.
  task automatic access(input bit st, input int sz, input bit un, input logic [63:0] a,
                        input logic [63:0] wd, input logic [63:0] rd, input int rdy_dly, input int rsp_dly);
    int off = int'(a[2:0]);
    bit mis = (a % (64'd1 << sz)) != 0;
    logic [63:0] e_addr = a - 64'(off);
    logic [7:0] e_mask = st ? 8'(((1 << (1 << sz)) - 1) << off) : 8'h00;
    logic [63:0] e_wd = st ? wd << (8 * off) : 64'd0;
    bit late = rsp_dly >= TO;
    logic [63:0] e_rd = (st || late) ? 64'd0 : ld_model(rd, off, sz, un);
    int n = late ? TO - 1 : rsp_dly;
    chk("ready_idle", ex_ready, 1);
    ex_valid = 1'b1; ex_is_store = st; ex_size = 2'(sz); ex_unsigned = un; ex_addr = a; ex_wdata = wd;
    @(negedge clk);
    ex_valid = 1'b0;
    scramble_ex();
    if (mis) begin
      chk("mis_wb_valid", wb_valid, 1);
      chk("mis_flag", wb_misalign, 1);
      chk("mis_buserr", wb_buserr, 0);
      chk("mis_no_req", mem_req_valid, 0);
      @(negedge clk);
      chk("mis_pulse_end", wb_valid, 0);
      chk("mis_ready", ex_ready, 1);
      return;
    end
    for (int i = 0; i <= rdy_dly; i++) begin
      chk("req_valid", mem_req_valid, 1);
      chk("req_addr", mem_addr, e_addr);
      chk("req_mask", mem_wmask, e_mask);
      chk("req_wdata", mem_wdata, e_wd);
      chk("req_we", mem_we, st);
      chk("req_busy", ex_ready, 0);
      mem_req_ready = (i == rdy_dly);
      @(negedge clk);
    end
    mem_req_ready = 1'b0;
    chk("one_transfer", mem_req_valid, 0);
    for (int k = 0; k <= n; k++) begin
      chk("wait_no_wb", wb_valid, 0);
      chk("wait_busy", ex_ready, 0);
      mem_rsp_valid = (k == rsp_dly);
      mem_rdata = (k == rsp_dly) ? rd : {$urandom, $urandom};
      @(negedge clk);
    end
    mem_rsp_valid = 1'b0;
    chk("wb_valid", wb_valid, 1);
    chk("wb_buserr", wb_buserr, late);
    chk("wb_misalign", wb_misalign, 0);
    chk("wb_rdata", wb_rdata, e_rd);
    chk("done_busy", ex_ready, 0);
    @(negedge clk);
    chk("wb_pulse_end", wb_valid, 0);
    chk("wb_buserr_clr", wb_buserr, 0);
    chk("wb_rdata_hold", wb_rdata, e_rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_ready", ex_ready, 1);
    chk("rst_req", mem_req_valid, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_mask", mem_wmask, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wb", {wb_valid, wb_misalign, wb_buserr}, 0);
    chk("rst_rdata", wb_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    access(0, 0, 0, 64'h8000_0005, 0, 64'h0000_8000_0000_0000, 0, 0);
    chk("lb_signed_val", wb_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    access(0, 0, 1, 64'h8000_0005, 0, 64'h0000_8000_0000_0000, 0, 0);
    chk("lbu_val", wb_rdata, 64'h80);
    access(1, 1, 0, 64'h8000_0006, 64'h1234, 0, 0, 1);
    access(0, 2, 0, 64'h8000_0002, 0, 0, 0, 0);
    access(1, 3, 0, 64'h8000_0010, 64'h0123_4567_89ab_cdef, 0, 5, 0);
    access(0, 2, 0, 64'h8000_0004, 0, 64'hDEAD_BEEF_0000_0000, 0, TO - 1);
    access(0, 3, 0, 64'h8000_0008, 0, 64'h1111_2222_3333_4444, 1, TO);
    // late response while idle must be ignored
    mem_rsp_valid = 1'b1;
    mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("late_rsp_ignored", wb_valid, 0);
    chk("late_rsp_ready", ex_ready, 1);
    // reset while waiting for the response
    ex_valid = 1'b1; ex_is_store = 1'b0; ex_size = 2'd3; ex_addr = 64'h8000_0040;
    mem_req_ready = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("rst_pre_wait", ex_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_ready", ex_ready, 1);
    chk("arst_req", mem_req_valid, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_wb", wb_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_wb", wb_valid, 0);
    end
    mem_rsp_valid = 1'b0;
    access(0, 1, 0, 64'h8000_0042, 0, 64'h0000_0000_8001_0000, 0, 0);
    for (int t = 0; t < 300; t++) begin
      int sz = $urandom_range(0, 3);
      logic [63:0] a = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 1);
      access(1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(0, 3), $urandom_range(0, TO + 1));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_req_ctrl.md
Name: lsu_req_ctrl

Overview:
Initiator side of the data-memory load/store interface. It accepts one load or store from the execute stage and checks natural alignment. It builds the doubleword-aligned address, write lane mask and lane-shifted write data, then runs a request/response handshake with the memory responder. For loads it extracts, sign-extends or zero-extends the addressed lanes and returns the result to writeback, stalling the pipeline while the access is in flight.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data path width (fixed at 64; lane logic assumes 8 byte lanes)
TIMEOUT, 255, max cycles waiting for mem_rsp_valid before a bus error (8-bit counter)

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  execute stage presents an access this cycle
ex_is_store  in  1  1 = store, 0 = load
ex_size  in  2  00 byte, 01 half, 10 word, 11 double
ex_unsigned  in  1  load zero-extend (ignored for stores and doubles)
ex_addr  in  ADDR_W  byte address
ex_wdata  in  DATA_W  store data, right-justified
ex_ready  out  1  LSU can accept (state IDLE)
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_we  out  1  write request
mem_addr  out  ADDR_W  ex_addr with [2:0] forced to 0
mem_wmask  out  8  byte-lane write enable
mem_wdata  out  DATA_W  store data shifted to lane ex_addr[2:0]
mem_rsp_valid  in  1  response (read data or write ack)
mem_rdata  in  DATA_W  full aligned doubleword
wb_valid  out  1  one-cycle completion pulse
wb_rdata  out  DATA_W  extended load result (0 for stores)
wb_misalign  out  1  completion was a misalignment fault
wb_buserr  out  1  completion was a response timeout

Behaviour:
- Reset (async, rst_n=0): state IDLE; ex_ready=1. mem_req_valid, mem_we, wb_valid, wb_misalign and wb_buserr are 0. mem_addr, mem_wmask, mem_wdata and wb_rdata are 0. Timeout counter is 0. Reset mid-transaction abandons it; no wb_valid is issued for it.
- Handshake: a transfer occurs on a cycle with mem_req_valid & mem_req_ready. While valid, all mem_* request outputs are stable until the transfer. mem_rsp_valid is honoured only in WAIT_RSP; in any other state it is ignored.
- States:
  - IDLE: on ex_valid, latch the access.
    - If misaligned (half: addr[0]!=0; word: addr[1:0]!=0; double: addr[2:0]!=0), go to DONE with misalign=1. No memory request is issued.
    - Otherwise go to REQ.
  - REQ: mem_req_valid=1. On transfer, go to WAIT_RSP and clear the counter.
  - WAIT_RSP: counter increments each cycle.
    - On mem_rsp_valid: capture the result and go to DONE.
    - If the counter reaches TIMEOUT without a response: go to DONE with buserr=1 and wb_rdata=0.
    - A response on the same cycle the counter hits TIMEOUT wins; it is a normal completion.
  - DONE: wb_valid=1 for exactly one cycle, then IDLE. ex_ready=0 in REQ, WAIT_RSP and DONE.
- Latency, zero-wait memory (ready=1, response the cycle after transfer): ex_valid at cycle 0 → request at cycle 1 → response at cycle 2 → wb_valid at cycle 3. Misaligned access: wb_valid at cycle 1.
- Write mask: base byte 01, half 03, word 0F, double FF, shifted left by addr[2:0]. mem_wdata = ex_wdata << (8*addr[2:0]). Loads drive wmask=0 and wdata=0.
- Load extraction: sh = mem_rdata >> (8*addr[2:0]). Take the low 8/16/32/64 bits. Sign-extend from the top bit unless ex_unsigned=1; doubles pass through unchanged.
- wb_misalign and wb_buserr are valid only with wb_valid; otherwise 0. wb_rdata holds its value until the next completion.

Test Plan:
- Load byte signed, addr 0x8000_0005, rdata 0x0000_8000_0000_0000 (lane 5 = 0x80) → mem_addr 0x8000_0000, wb_rdata 0xFFFF_FFFF_FFFF_FF80; with ex_unsigned=1 → 0x80. wb_valid at cycle 3.
- Store half, addr 0x8000_0006, wdata 0x1234 → mem_we=1, wmask 0xC0, mem_wdata 0x1234_0000_0000_0000, mem_addr 0x8000_0000. wb_valid follows the ack.
- Load word, addr 0x8000_0002 → wb_misalign=1 at cycle 1; mem_req_valid never asserts.
- Backpressure: mem_req_ready held low for 5 cycles → mem_req_valid, mem_addr and mem_wmask stay stable for all 5 cycles; exactly one transfer; ex_ready=0 throughout.
- No response with TIMEOUT=4 → wb_buserr=1, wb_rdata=0, return to IDLE. A late mem_rsp_valid arriving in IDLE is ignored.
- rst_n pulled low in WAIT_RSP → outputs return to reset values immediately; no wb_valid; the next access proceeds normally.
